// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: op and state
// encodings plus the small decode helpers used at request acceptance.
package lsu_pkg;

  typedef enum logic [2:0] {
    LSU_LB  = 3'd0,
    LSU_LH  = 3'd1,
    LSU_LW  = 3'd2,
    LSU_LBU = 3'd3,
    LSU_LHU = 3'd4,
    LSU_SB  = 3'd5,
    LSU_SH  = 3'd6,
    LSU_SW  = 3'd7
  } lsu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_STORE  = 3'd2,
    ST_RMW_RD = 3'd3,
    ST_RMW_WR = 3'd4,
    ST_FAULT  = 3'd5,
    ST_RESP   = 3'd6
  } lsu_state_e;

  function automatic logic is_store(lsu_op_e op);
    return (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
  endfunction

  // Halfwords need an even offset, words need offset 0; bytes always fit.
  function automatic logic align_ok(lsu_op_e op, logic [1:0] off);
    case (op)
      LSU_LH, LSU_LHU, LSU_SH: return ~off[0];
      LSU_LW, LSU_SW:          return (off == 2'b00);
      default:                 return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian byte-lane steering: extracts/extends sub-word load data and
// merges sub-word store data into an existing memory word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  lsu_op_e     op,
  input  logic [1:0]  offset,
  input  logic [31:0] load_word,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte/half out of the read word and extend it.
  always_comb begin
    byte_sel  = load_word[{offset, 3'b000} +: 8];
    half_sel  = load_word[{offset[1], 4'b0000} +: 16];
    load_data = '0;
    case (op)
      LSU_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
      LSU_LH:  load_data = {{16{half_sel[15]}}, half_sel};
      LSU_LW:  load_data = load_word;
      LSU_LBU: load_data = {24'd0, byte_sel};
      LSU_LHU: load_data = {16'd0, half_sel};
      default: load_data = '0;
    endcase
  end

  // Replace only the addressed lane(s) of the old word with store data.
  always_comb begin
    merged_word = old_word;
    case (op)
      LSU_SB:  merged_word[{offset, 3'b000} +: 8]     = wdata[7:0];
      LSU_SH:  merged_word[{offset[1], 4'b0000} +: 16] = wdata[15:0];
      LSU_SW:  merged_word = wdata;
      default: merged_word = old_word;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit in front of a word-indexed data memory.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ST_IDLE   | ready for a request; no memory activity
//   ST_LOAD   | read addressed word, extract/extend into resp_rdata
//   ST_STORE  | full-word write of captured store data
//   ST_RMW_RD | read old word for a sub-word store into merge register
//   ST_RMW_WR | write old word with selected lane(s) replaced
//   ST_FAULT  | misaligned or out-of-range request, no memory activity
//   ST_RESP   | resp_valid pulse, then back to idle
//
// Memory-side signals are decoded from the registered state only, so an
// asynchronous reset removes a pending write strobe immediately.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 32,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_fault,
  output logic [31:0]       mem_access_addr,
  output logic [31:0]       mem_write_data,
  output logic              mem_write_en,
  output logic              mem_read_en,
  input  logic [31:0]       mem_read_data
);

  lsu_state_e        state;
  lsu_op_e           op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       old_q;

  lsu_op_e           req_op_e;
  logic [ADDR_W-3:0] req_widx;
  logic              range_ok;
  logic              req_fault;
  logic [31:0]       word_idx_q;
  logic [31:0]       load_data;
  logic [31:0]       merged_word;

  assign req_op_e   = lsu_op_e'(req_op);
  assign req_widx   = req_addr[ADDR_W-1:2];
  assign range_ok   = (64'(req_widx) <= 64'(MEM_WORDS));
  assign req_fault  = !align_ok(req_op_e, req_addr[1:0]) || !range_ok;
  assign word_idx_q = 32'(addr_q[ADDR_W-1:2]);

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);

  lsu_lane_align u_lane_align (
    .op          (op_q),
    .offset      (addr_q[1:0]),
    .load_word   (mem_read_data),
    .old_word    (old_q),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  // Sequencer: captures the request, routes it, and registers the response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      op_q       <= LSU_LB;
      addr_q     <= '0;
      wdata_q    <= '0;
      old_q      <= '0;
      resp_rdata <= '0;
      resp_fault <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_q    <= req_op_e;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            if (req_fault)
              state <= ST_FAULT;
            else if (req_op_e == LSU_SW)
              state <= ST_STORE;
            else if (is_store(req_op_e))
              state <= ST_RMW_RD;
            else
              state <= ST_LOAD;
          end
        end
        ST_FAULT: begin
          resp_rdata <= '0;
          resp_fault <= 1'b1;
          state      <= ST_RESP;
        end
        ST_LOAD: begin
          resp_rdata <= load_data;
          resp_fault <= 1'b0;
          state      <= ST_RESP;
        end
        ST_STORE: begin
          resp_rdata <= '0;
          resp_fault <= 1'b0;
          state      <= ST_RESP;
        end
        ST_RMW_RD: begin
          old_q <= mem_read_data;
          state <= ST_RMW_WR;
        end
        ST_RMW_WR: begin
          resp_rdata <= '0;
          resp_fault <= 1'b0;
          state      <= ST_RESP;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Memory port decode; address and data are forced to zero when idle.
  always_comb begin
    mem_read_en     = 1'b0;
    mem_write_en    = 1'b0;
    mem_access_addr = '0;
    mem_write_data  = '0;
    case (state)
      ST_LOAD, ST_RMW_RD: begin
        mem_read_en     = 1'b1;
        mem_access_addr = word_idx_q;
      end
      ST_STORE: begin
        mem_write_en    = 1'b1;
        mem_access_addr = word_idx_q;
        mem_write_data  = wdata_q;
      end
      ST_RMW_WR: begin
        mem_write_en    = 1'b1;
        mem_access_addr = word_idx_q;
        mem_write_data  = merged_word;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: a byte-level reference model predicts
// each response; a monitor compares responses and memory-port behaviour.
module tb_mem_stage_lsu;

  localparam int MEM_WORDS = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] mem_access_addr;
  logic [31:0] mem_write_data;
  logic        mem_write_en;
  logic        mem_read_en;
  logic [31:0] mem_read_data;

  mem_stage_lsu #(.MEM_WORDS(MEM_WORDS), .ADDR_W(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_op          (req_op),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_fault      (resp_fault),
    .mem_access_addr (mem_access_addr),
    .mem_write_data  (mem_write_data),
    .mem_write_en    (mem_write_en),
    .mem_read_en     (mem_read_en),
    .mem_read_data   (mem_read_data)
  );

  always #5 clk = ~clk;

  // Data memory attached to the DUT, and the model's view of it.
  logic [31:0] mem     [0:MEM_WORDS];
  logic [31:0] ref_mem [0:MEM_WORDS];

  assign mem_read_data = (mem_access_addr <= MEM_WORDS) ? mem[mem_access_addr[5:0]] : 32'hBAD0BAD0;

  always @(posedge clk) begin
    if (mem_write_en && mem_access_addr <= MEM_WORDS)
      mem[mem_access_addr[5:0]] <= mem_write_data;
  end

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit busy   = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        fault;
    int          lat;
    int          rd;
    int          wr;
    logic [31:0] widx;
    int          acc_cyc;
  } exp_t;

  exp_t sb_q[$];

  // Reference model: byte-addressed arithmetic over ref_mem.
  task automatic model(input int op, input logic [31:0] addr, input logic [31:0] wd,
                       output exp_t e);
    int unsigned widx = addr >> 2;
    int unsigned off  = addr % 4;
    logic [31:0] w, b, h;
    bit misal;
    misal = ((op == 1 || op == 4 || op == 6) && (off % 2 != 0)) ||
            ((op == 2 || op == 7) && off != 0);
    e.fault = misal || (widx > MEM_WORDS);
    e.rdata = 32'd0;
    e.widx  = widx;
    e.rd    = 0;
    e.wr    = 0;
    e.lat   = 2;
    if (!e.fault) begin
      w = ref_mem[widx];
      b = (w >> (8 * off)) & 32'hFF;
      h = (w >> (8 * off)) & 32'hFFFF;
      case (op)
        0: begin e.rd = 1; e.rdata = (b >= 128) ? b - 32'd256   : b; end
        1: begin e.rd = 1; e.rdata = (h >= 32768) ? h - 32'd65536 : h; end
        2: begin e.rd = 1; e.rdata = w; end
        3: begin e.rd = 1; e.rdata = b; end
        4: begin e.rd = 1; e.rdata = h; end
        5: begin
          e.rd = 1; e.wr = 1; e.lat = 3;
          ref_mem[widx] = (w & ~(32'hFF << (8 * off))) | ((wd & 32'hFF) << (8 * off));
        end
        6: begin
          e.rd = 1; e.wr = 1; e.lat = 3;
          ref_mem[widx] = (w & ~(32'hFFFF << (8 * off))) | ((wd & 32'hFFFF) << (8 * off));
        end
        default: begin e.wr = 1; ref_mem[widx] = wd; end
      endcase
    end
  endtask

  int rd_cnt, wr_cnt, both_cnt, addr_bad, idle_bad, ready_bad;

  // Monitor: per-cycle memory-port bookkeeping, response scoreboard pop.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (reset) begin
      rd_cnt = 0; wr_cnt = 0; both_cnt = 0; addr_bad = 0; idle_bad = 0; ready_bad = 0;
    end else begin
      if (mem_read_en && mem_write_en) both_cnt++;
      if (mem_read_en) rd_cnt++;
      if (mem_write_en) wr_cnt++;
      if (mem_read_en || mem_write_en) begin
        if (sb_q.size() != 0 && mem_access_addr !== sb_q[0].widx) addr_bad++;
      end else if (mem_access_addr !== 32'd0 || mem_write_data !== 32'd0) begin
        idle_bad++;
      end
      if (busy && req_ready) ready_bad++;
      if (resp_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp actual=resp_valid required=no_response");
        end else begin
          e = sb_q.pop_front();
          check({e.name, "_rdata"},   resp_rdata, e.rdata);
          check({e.name, "_fault"},   32'(resp_fault), 32'(e.fault));
          check({e.name, "_latency"}, cyc - e.acc_cyc, e.lat);
          check({e.name, "_rd_cyc"},  rd_cnt, e.rd);
          check({e.name, "_wr_cyc"},  wr_cnt, e.wr);
          check({e.name, "_addr"},    addr_bad, 0);
          check({e.name, "_idle_out"}, idle_bad, 0);
          check({e.name, "_ready_low"}, ready_bad, 0);
          check({e.name, "_rd_wr_excl"}, both_cnt, 0);
        end
        rd_cnt = 0; wr_cnt = 0; both_cnt = 0; addr_bad = 0; idle_bad = 0; ready_bad = 0;
        busy = 0;
      end
    end
  end

  task automatic issue(input string name, input int op, input logic [31:0] addr,
                       input logic [31:0] wd);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_ready_timeout actual=0 required=1", name);
      return;
    end
    model(op, addr, wd, e);
    e.name    = name;
    e.acc_cyc = cyc;
    sb_q.push_back(e);
    req_valid = 1'b1;
    req_op    = op[2:0];
    req_addr  = addr;
    req_wdata = wd;
    @(posedge clk);
    busy = 1;
    #1;
    req_valid = 1'b0;
    req_op    = 3'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain"}, sb_q.size(), 0);
    #1;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_req_ready"},  32'(req_ready), 1);
    check({name, "_resp_valid"}, 32'(resp_valid), 0);
    check({name, "_resp_rdata"}, resp_rdata, 0);
    check({name, "_resp_fault"}, 32'(resp_fault), 0);
    check({name, "_mem_we"},     32'(mem_write_en), 0);
    check({name, "_mem_re"},     32'(mem_read_en), 0);
    check({name, "_mem_addr"},   mem_access_addr, 0);
    check({name, "_mem_wdata"},  mem_write_data, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] saved;
    int op, n;
    logic [31:0] addr;

    reset = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i <= MEM_WORDS; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    issue("sw_10", 7, 32'h10, 32'hDEADBEEF);
    drain("sw_10");
    check("sw_10_mem4", mem[4], 32'hDEADBEEF);
    issue("lw_10", 2, 32'h10, 32'h0);
    issue("sb_12", 5, 32'h12, 32'h55);
    drain("sb_12");
    check("sb_12_mem4", mem[4], 32'hDE55BEEF);
    issue("lh_12",  1, 32'h12, 32'h0);
    issue("lhu_12", 4, 32'h12, 32'h0);
    issue("lb_11",  0, 32'h11, 32'h0);
    issue("lbu_13", 3, 32'h13, 32'h0);
    issue("lw_06",  2, 32'h06, 32'h0);
    issue("sh_13",  6, 32'h13, 32'h1234);
    issue("lw_80",  2, 32'h80, 32'h0);
    issue("sw_84",  7, 32'h84, 32'hCAFEF00D);
    drain("directed");
    check("faults_mem4", mem[4], 32'hDE55BEEF);

    for (int k = 0; k < 300; k++) begin
      op = $urandom_range(0, 7);
      if ($urandom_range(0, 9) < 8) addr = $urandom_range(0, 4 * MEM_WORDS + 11);
      else addr = $urandom;
      issue("rand", op, addr, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain("rand");

    // Reset in the write cycle of a sub-word store must suppress the write.
    saved = mem[4];
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd5; req_addr = 32'h10; req_wdata = ~saved;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_write_en && n < 10);
    check("rst_reach_rmw_wr", 32'(mem_write_en), 1);
    reset = 1'b1;
    #1;
    check("rst_we_drop", 32'(mem_write_en), 0);
    check("rst_no_resp", 32'(resp_valid), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_outputs("post_reset");
    @(negedge clk);
    check("post_reset_ready2", 32'(req_ready), 1);
    check("rst_mem4_kept", mem[4], saved);

    issue("after_rst_lw", 2, 32'h10, 32'h0);
    drain("after_rst");

    for (int i = 0; i <= MEM_WORDS; i++) check($sformatf("final_mem%0d", i), mem[i], ref_mem[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Load/store unit for the MEM pipeline stage, sitting directly upstream of the word-indexed data memory.
- Accepts byte-addressed load/store requests from EX/MEM over a valid/ready handshake.
- Converts each request to word-indexed memory accesses, performs read-modify-write for sub-word stores, and extracts/extends sub-word load data.
- Returns a one-cycle response pulse to MEM/WB, with a fault flag for misaligned or out-of-range addresses.

Parameters:
- MEM_WORDS, 32, highest valid word index; valid word indices are 0..MEM_WORDS inclusive.
- ADDR_W, 32, byte-address width.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request; high only in IDLE.
- req_op  input  3  0=LB 1=LH 2=LW 3=LBU 4=LHU 5=SB 6=SH 7=SW.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  32  store data; byte/half taken from the low bits.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  32  extended load result; 0 for stores and faults.
- resp_fault  output  1  misaligned or out-of-range request; qualified by resp_valid.
- mem_access_addr  output  32  word index = {2'b00, addr[31:2]}.
- mem_write_data  output  32  word to write.
- mem_write_en  output  1  memory write strobe; memory writes on the rising edge.
- mem_read_en  output  1  memory read enable.
- mem_read_data  input  32  combinational memory read data.

Behaviour:
- Reset is asynchronous, active-high and dominates:
  - state=IDLE; resp_valid=0, resp_rdata=0, resp_fault=0.
  - mem_write_en=0, mem_read_en=0, mem_access_addr=0, mem_write_data=0.
- Memory-side outputs are decoded from the registered state. Asserting reset mid-operation therefore drops mem_write_en in the same cycle, so no write follows.
- Byte lanes are little-endian: offset 0 is bits[7:0], offset 3 is bits[31:24]. A half at offset 2 is bits[31:16].
- Handshake: a request is accepted on a rising edge where req_valid & req_ready. Op, address and wdata are captured into a request register. req_ready is 0 in every state except IDLE.
- Fault check at acceptance:
  - LH/LHU/SH with addr[0]=1 → fault.
  - LW/SW with addr[1:0]≠0 → fault.
  - Any op with addr[31:2] > MEM_WORDS → fault.
- States and transitions:
  - IDLE: accept request → FAULT, LOAD, STORE or RMW_RD according to op and the fault check.
  - FAULT: no memory enables → RESP with resp_fault=1, rdata=0.
  - LOAD: mem_read_en=1, addr driven. At the edge, mem_read_data is extracted and extended into resp_rdata → RESP.
    - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - STORE (SW): mem_write_en=1, mem_write_data=wdata → RESP.
  - RMW_RD (SB/SH): mem_read_en=1. The old word is captured into a merge register → RMW_WR.
  - RMW_WR: mem_write_en=1, mem_write_data = old word with the selected lane(s) replaced → RESP.
  - RESP: resp_valid=1 for exactly this cycle → IDLE.
- Latency from the acceptance edge to resp_valid high:
  - FAULT, LW-class loads and SW: 2 cycles.
  - SB/SH: 3 cycles.
- Back-to-back throughput: req_ready returns in the cycle after RESP.
- mem_read_en and mem_write_en are never high together. Both are 0 in IDLE, FAULT and RESP, and mem_access_addr is 0 in those states.
- resp_rdata and resp_fault hold their values outside RESP; only resp_valid qualifies them.
- req_valid deasserting while the unit is busy has no effect; the captured request completes.

Decomposition:
- Package lsu_pkg:
  - op encodings LSU_LB..LSU_SW.
  - state encoding for IDLE/LOAD/STORE/RMW_RD/RMW_WR/FAULT/RESP.
  - functions is_store(op) and align_ok(op, addr[1:0]).
- Sub-module lsu_lane_align, purely combinational:
  - load path: (op, offset, word) → extended load data.
  - store path: (op, offset, old word, wdata) → merged word.

Test Plan:
- SW addr 0x10 wdata 0xDEADBEEF → write to word 4 two cycles after acceptance. LW 0x10 → resp_rdata=0xDEADBEEF, resp_fault=0.
- Word 4 = 0xDEADBEEF; SB addr 0x12 wdata 0x55 → one read cycle, then a write of 0xDE55BEEF; resp 3 cycles after acceptance; req_ready low throughout.
- Word 4 = 0xDE55BEEF: LH 0x12 → 0xFFFFDE55; LHU 0x12 → 0x0000DE55; LB 0x11 → 0xFFFFFFBE; LBU 0x13 → 0x000000DE.
- LW 0x06 and SH 0x13 → resp_fault=1, resp_rdata=0, mem_write_en and mem_read_en never asserted; memory unchanged.
- LW 0x80 (index 32) accepted → no fault. SW 0x84 (index 33) → fault, no write.
- Reset asserted during RMW_WR of SB 0x10 → mem_write_en falls immediately, word 4 unchanged, no resp_valid. Outputs are at reset values, and req_ready=1 on the first cycle after reset deasserts.
